// File: rtl/scan_test_ctrl.sv
// rtl/scan_test_ctrl.sv - scan chain driver: serialise patterns, capture, unload responses
// Define SCAN_MISR_EN to fold every unloaded bit of a test set into one MISR signature word.
module scan_test_ctrl #(
  parameter int                   CHAIN_LEN = 8,
  parameter logic [CHAIN_LEN-1:0] MISR_POLY = 8'h1D
) (
  input  logic                 C,
  input  logic                 global_reset,
  input  logic                 pat_valid,
  input  logic [CHAIN_LEN-1:0] pat_data,
  input  logic                 pat_last,
  output logic                 pat_ready,
  output logic                 nbar_t,
  output logic                 si,
  input  logic                 so,
  output logic                 rsp_valid,
  output logic [CHAIN_LEN-1:0] rsp_data,
  input  logic                 rsp_ready,
  output logic                 busy
);
  localparam int            CW       = $clog2(CHAIN_LEN + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(CHAIN_LEN - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE, UNLOAD} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] pat_q, pat_d;
  logic [CHAIN_LEN-1:0] rsp_data_q, rsp_data_d;
  logic                 last_q, last_d;
  logic                 nbar_t_q, nbar_t_d;
  logic                 si_q, si_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 have_prev_q, have_prev_d;
  logic                 busy_q, busy_d;
  logic                 collect;
  logic [CHAIN_LEN-1:0] word;

`ifdef SCAN_MISR_EN
  logic [CHAIN_LEN-1:0] sig_q, sig_d;
  logic                 fb;

  always_comb begin
    fb    = sig_q[CHAIN_LEN-1] ^ so;
    word  = (sig_q << 1) ^ (fb ? MISR_POLY : '0);
    sig_d = sig_q;
    if (rsp_valid_q && rsp_ready) sig_d = '0;
    if (collect) sig_d = word;
  end
`else
  logic [CHAIN_LEN-1:0] sh_q, sh_d;

  // First bit seen on so ends up in bit 0 after CHAIN_LEN right shifts.
  always_comb begin
    word = {so, sh_q[CHAIN_LEN-1:1]};
    sh_d = collect ? word : sh_q;
  end
`endif

  assign pat_ready = (state_q == IDLE) && !rsp_valid_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pat_d       = pat_q;
    last_d      = last_q;
    nbar_t_d    = nbar_t_q;
    si_d        = si_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    have_prev_d = have_prev_q;
    collect     = 1'b0;
    if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pat_valid && pat_ready) begin
          state_d  = SHIFT;
          pat_d    = pat_data;
          last_d   = pat_last;
          cnt_d    = '0;
          nbar_t_d = 1'b1;
          si_d     = pat_data[0];
        end
      end
      SHIFT: begin
        collect = have_prev_q;
        cnt_d   = cnt_q + CW'(1);
        pat_d   = {pat_q[0], pat_q[CHAIN_LEN-1:1]};
        si_d    = pat_q[1];
        if (cnt_q == LAST_BIT) begin
          state_d  = CAPTURE;
          cnt_d    = '0;
          nbar_t_d = 1'b0;
          si_d     = 1'b0;
`ifndef SCAN_MISR_EN
          if (have_prev_q) begin
            rsp_data_d  = word;
            rsp_valid_d = 1'b1;
          end
`endif
        end
      end
      CAPTURE: begin
        have_prev_d = 1'b1;
        if (!last_q) begin
          state_d = IDLE;
        end else if (!rsp_valid_q || rsp_ready) begin
          // Unload may only start once the previous response is gone this edge.
          state_d  = UNLOAD;
          cnt_d    = '0;
          nbar_t_d = 1'b1;
        end
      end
      UNLOAD: begin
        collect = 1'b1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          state_d     = IDLE;
          cnt_d       = '0;
          nbar_t_d    = 1'b0;
          rsp_data_d  = word;
          rsp_valid_d = 1'b1;
          have_prev_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge C) begin
    if (global_reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pat_q       <= '0;
      last_q      <= 1'b0;
      nbar_t_q    <= 1'b0;
      si_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      have_prev_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SCAN_MISR_EN
      sig_q       <= '0;
`else
      sh_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pat_q       <= pat_d;
      last_q      <= last_d;
      nbar_t_q    <= nbar_t_d;
      si_q        <= si_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      have_prev_q <= have_prev_d;
      busy_q      <= busy_d;
`ifdef SCAN_MISR_EN
      sig_q       <= sig_d;
`else
      sh_q        <= sh_d;
`endif
    end
  end

  assign nbar_t    = nbar_t_q;
  assign si        = si_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_scan_test_ctrl.sv
// tb/tb_scan_test_ctrl.sv - scoreboard bench for scan_test_ctrl driving an 8-flop toggle chain
module tb_scan_test_ctrl;
  localparam int         N    = 8;
  localparam logic [7:0] POLY = 8'h1D;

  logic       C = 1'b0;
  logic       global_reset = 1'b1;
  logic       pat_valid = 1'b0;
  logic [7:0] pat_data = 8'h00;
  logic       pat_last = 1'b0;
  logic       pat_ready;
  logic       nbar_t;
  logic       si;
  logic       so;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_ready = 1'b0;
  logic       busy;

  scan_test_ctrl #(.CHAIN_LEN(N), .MISR_POLY(POLY)) dut (
    .C(C), .global_reset(global_reset), .pat_valid(pat_valid), .pat_data(pat_data),
    .pat_last(pat_last), .pat_ready(pat_ready), .nbar_t(nbar_t), .si(si), .so(so),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready), .busy(busy)
  );

  always #5 C = ~C;

  // Circuit under test: dff cells with D = ~Q; bit 0 is the tail, so the word reads like the pattern.
  logic [7:0] ch = 8'h00;
  assign so = ch[0];
  always @(posedge C) begin
    if (nbar_t) ch <= {si, ch[7:1]};
    else        ch <= ~ch;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] fold(input logic [7:0] s, input logic [7:0] w);
    logic [7:0] r;
    logic       fb;
    r = s;
    for (int i = 0; i < 8; i++) begin
      fb = r[7] ^ w[i];
      r  = {r[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
    end
    return r;
  endfunction

  logic rand_ready = 1'b0;
  logic force_ready = 1'b1;
  always @(posedge C) begin
    #1;
    rsp_ready = rand_ready ? 1'($urandom_range(0, 1)) : force_ready;
  end

  logic [7:0] iss_q[$];
  logic       iss_last_q[$];
  logic [7:0] exp_q[$];
  logic       m_have_prev = 1'b0, m_pend_unload = 1'b0, m_unload_win = 1'b0, m_cur_last = 1'b0;
  logic [7:0] m_cur_pat = 8'h00, m_sig = 8'h00, prev_rd = 8'h00, last_rsp = 8'h00;
  logic       prev_nb = 1'b0, prev_rv = 1'b0, prev_rr = 1'b0;
  int         win_cnt = 0, rsp_cnt = 0;

  // Reference: a response is the chain content when the next shift/unload window opens.
  always @(negedge C) begin
    if (global_reset) begin
      iss_q.delete(); iss_last_q.delete(); exp_q.delete();
      m_have_prev = 1'b0; m_pend_unload = 1'b0; m_sig = 8'h00;
      prev_nb = 1'b0; prev_rv = 1'b0; prev_rr = 1'b0; win_cnt = 0;
    end else begin
      if (nbar_t && !prev_nb) begin
        chk("busy_in_window", busy, 1);
        m_unload_win = m_pend_unload;
        if (!m_unload_win) begin
          if (iss_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL window_without_pattern: got shift window expected none");
          end else begin
            m_cur_pat  = iss_q.pop_front();
            m_cur_last = iss_last_q.pop_front();
          end
        end
        if (m_have_prev) begin
`ifdef SCAN_MISR_EN
          m_sig = fold(m_sig, ch);
          if (m_unload_win) begin
            exp_q.push_back(m_sig);
            m_sig = 8'h00;
          end
`else
          exp_q.push_back(ch);
`endif
        end
        win_cnt = 0;
      end
      if (nbar_t) win_cnt++;
      if (!nbar_t && prev_nb) begin
        chk("shift_len", win_cnt, N);
        if (m_unload_win) begin
          chk("chain_after_unload", ch, 8'h00);
          m_have_prev = 1'b0; m_pend_unload = 1'b0;
        end else begin
          chk("chain_after_load", ch, m_cur_pat);
          m_have_prev = 1'b1; m_pend_unload = m_cur_last;
        end
      end
      if (rsp_valid) begin
        if (prev_rv && !prev_rr) chk("rsp_stable", rsp_data, prev_rd);
        if (rsp_ready) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_rsp: got %0h expected no response", rsp_data);
          end else begin
            chk("rsp_data", rsp_data, exp_q.pop_front());
          end
          last_rsp = rsp_data;
          rsp_cnt++;
        end
      end
      prev_nb = nbar_t; prev_rv = rsp_valid; prev_rr = rsp_ready; prev_rd = rsp_data;
    end
  end

  task automatic send(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    @(posedge C); #1;
    pat_valid = 1'b1; pat_data = d; pat_last = l;
    forever begin
      @(negedge C);
      if (pat_ready) begin
        iss_q.push_back(d);
        iss_last_q.push_back(l);
        break;
      end
      n++;
      if (n > 500) begin
        checks++; failures++;
        $display("FAIL send_timeout: got pat_ready=0 expected 1 within 500 cycles");
        break;
      end
    end
    @(posedge C); #1;
    pat_valid = 1'b0; pat_data = 8'($urandom); pat_last = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge C);
      n++;
    end while ((busy || rsp_valid) && n < 600);
    if (n >= 600) begin
      checks++; failures++;
      $display("FAIL done_timeout: got busy=%0d rsp_valid=%0d expected idle", busy, rsp_valid);
    end
    @(negedge C);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] d0;
    int n, base, np;
    repeat (2) @(posedge C);
    #1 global_reset = 1'b0;
    @(negedge C);
    chk("reset_nbar_t", nbar_t, 0);
    chk("reset_si", si, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_data", rsp_data, 8'h00);
    chk("reset_busy", busy, 0);
    chk("reset_pat_ready", pat_ready, 1);

    force_ready = 1'b1;
    send(8'hA5, 1'b1);
    wait_done();
`ifndef SCAN_MISR_EN
    chk("single_a5", last_rsp, 8'h5A);
`endif

    send(8'h0F, 1'b0);
    send(8'hF0, 1'b1);
    wait_done();
`ifndef SCAN_MISR_EN
    chk("two_pat_unload", last_rsp, 8'h0F);
`endif

    force_ready = 1'b0;
    send(8'h0F, 1'b0);
    send(8'hF0, 1'b0);
`ifndef SCAN_MISR_EN
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge C); n++; end
    chk("bp_rsp_valid_seen", rsp_valid, 1);
    d0 = rsp_data;
    repeat (5) begin
      @(negedge C);
      chk("bp_pat_ready", pat_ready, 0);
      chk("bp_nbar_t", nbar_t, 0);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_data", rsp_data, d0);
    end
    force_ready = 1'b1;
    @(negedge C);
    @(negedge C);
    chk("bp_release_pat_ready", pat_ready, 1);
`endif
    force_ready = 1'b1;
    send(8'h3C, 1'b1);
    wait_done();

    send(8'hFF, 1'b1);
    n = 0;
    base = 0;
    while (base < 4 && n < 100) begin
      @(negedge C);
      if (nbar_t) base++;
      n++;
    end
    chk("rst_reached_shift4", base, 4);
    @(posedge C); #1 global_reset = 1'b1;
    @(posedge C); #1 global_reset = 1'b0;
    @(negedge C);
    chk("midrst_nbar_t", nbar_t, 0);
    chk("midrst_si", si, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_pat_ready", pat_ready, 1);
    base = rsp_cnt;
    send(8'h00, 1'b1);
    wait_done();
`ifdef SCAN_MISR_EN
    chk("after_rst_sig", last_rsp, 8'hC4);
`else
    chk("after_rst_rsp", last_rsp, 8'hFF);
`endif
    chk("after_rst_rsp_count", rsp_cnt - base, 1);

    rand_ready = 1'b1;
    for (int s = 0; s < 25; s++) begin
      np = $urandom_range(1, 3);
      for (int p = 0; p < np; p++) begin
        send(8'($urandom), (p == np - 1));
        repeat ($urandom_range(0, 3)) @(posedge C);
      end
      wait_done();
    end
    chk("leftover_expected", exp_q.size(), 0);
    chk("leftover_patterns", iss_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
